// File: rtl/block_window_loader.sv
// block_window_loader: scans a time-sorted beatmap in block memory and publishes up to
// 12 upcoming entries that fall within WINDOW of the latched start time. Optional macro: HIT_MASK_EN.
module block_window_loader #(
   parameter int unsigned NUM_BLOCKS  = 256,
   parameter int unsigned WINDOW      = 16383,
   parameter int unsigned MEM_LATENCY = 2
) (
   input  logic              clk_in,
   input  logic              rst_in,
   input  logic [17:0]       curr_time_in,
   input  logic              start_in,
   output logic [7:0]        mem_addr_out,
   input  logic [45:0]       mem_data_in,
   input  logic              hit_valid_in,
   input  logic [7:0]        hit_ID_in,
   output logic [11:0][11:0] block_x_out,
   output logic [11:0][11:0] block_y_out,
   output logic [11:0][13:0] block_z_out,
   output logic [11:0]       block_color_out,
   output logic [11:0][2:0]  block_direction_out,
   output logic [11:0][7:0]  block_ID_out,
   output logic [11:0]       block_visible_out,
   output logic              update_out,
   output logic              busy_out
);

   localparam logic [7:0]  LAST_ADDR = 8'(NUM_BLOCKS - 1);
   localparam logic [7:0]  WAIT_LAST = 8'((MEM_LATENCY > 1) ? MEM_LATENCY - 2 : 0);
   localparam logic [17:0] WINDOW_T  = 18'(WINDOW);

   typedef enum logic [2:0] {IDLE, ISSUE, WAIT, EVAL, PUBLISH} state_t;

   state_t            state_q, state_d;
   logic [17:0]       t0_q, t0_d;
   logic [7:0]        addr_q, addr_d;
   logic [3:0]        fill_q, fill_d;
   logic [7:0]        wcnt_q, wcnt_d;
   logic              upd_q, upd_d;

   logic [11:0][11:0] sh_x_q, sh_x_d, pub_x_q, pub_x_d;
   logic [11:0][11:0] sh_y_q, sh_y_d, pub_y_q, pub_y_d;
   logic [11:0][13:0] sh_z_q, sh_z_d, pub_z_q, pub_z_d;
   logic [11:0]       sh_c_q, sh_c_d, pub_c_q, pub_c_d;
   logic [11:0][2:0]  sh_dir_q, sh_dir_d, pub_dir_q, pub_dir_d;
   logic [11:0][7:0]  sh_id_q, sh_id_d, pub_id_q, pub_id_d;
   logic [11:0]       sh_vis_q, sh_vis_d, pub_vis_q, pub_vis_d;

   logic [17:0]       e_time;
   logic [17:0]       e_delta;
   logic              e_early;
   logic              e_masked;
   logic              scan_end;

   assign e_time  = mem_data_in[45:28];
   assign e_delta = e_time - t0_q;
   assign e_early = (e_time < t0_q);

`ifdef HIT_MASK_EN
   logic [NUM_BLOCKS-1:0] mask_q, mask_d;

   // A hit registers this cycle, so it first affects an EVAL in the following cycle.
   always_comb begin
      mask_d = mask_q;
      if (hit_valid_in && (32'(hit_ID_in) < NUM_BLOCKS)) mask_d[hit_ID_in] = 1'b1;
   end

   always_ff @(posedge clk_in) begin
      if (rst_in) mask_q <= '0;
      else        mask_q <= mask_d;
   end

   assign e_masked = mask_q[addr_q];
`else
   logic unused_hit;
   assign unused_hit = ^{hit_valid_in, hit_ID_in};
   assign e_masked   = 1'b0;
`endif

   always_comb begin
      state_d   = state_q;
      t0_d      = t0_q;
      addr_d    = addr_q;
      fill_d    = fill_q;
      wcnt_d    = wcnt_q;
      upd_d     = 1'b0;
      scan_end  = 1'b0;
      sh_x_d    = sh_x_q;
      sh_y_d    = sh_y_q;
      sh_z_d    = sh_z_q;
      sh_c_d    = sh_c_q;
      sh_dir_d  = sh_dir_q;
      sh_id_d   = sh_id_q;
      sh_vis_d  = sh_vis_q;
      pub_x_d   = pub_x_q;
      pub_y_d   = pub_y_q;
      pub_z_d   = pub_z_q;
      pub_c_d   = pub_c_q;
      pub_dir_d = pub_dir_q;
      pub_id_d  = pub_id_q;
      pub_vis_d = pub_vis_q;

      case (state_q)
         IDLE: begin
            if (start_in) begin
               t0_d     = curr_time_in;
               addr_d   = '0;
               fill_d   = '0;
               sh_x_d   = '0;
               sh_y_d   = '0;
               sh_z_d   = '0;
               sh_c_d   = '0;
               sh_dir_d = '0;
               sh_id_d  = '0;
               sh_vis_d = '0;
               state_d  = ISSUE;
            end
         end
         ISSUE: begin
            wcnt_d  = '0;
            state_d = (MEM_LATENCY > 1) ? WAIT : EVAL;
         end
         WAIT: begin
            if (wcnt_q == WAIT_LAST) state_d = EVAL;
            else                     wcnt_d  = wcnt_q + 8'd1;
         end
         EVAL: begin
            // Entries are time-sorted, so the first one past the window ends the scan.
            if (!(e_early || e_masked)) begin
               if (e_delta > WINDOW_T) begin
                  scan_end = 1'b1;
               end else begin
                  sh_x_d[fill_q]   = mem_data_in[27:16];
                  sh_y_d[fill_q]   = mem_data_in[15:4];
                  sh_z_d[fill_q]   = e_delta[13:0];
                  sh_c_d[fill_q]   = mem_data_in[3];
                  sh_dir_d[fill_q] = mem_data_in[2:0];
                  sh_id_d[fill_q]  = addr_q;
                  sh_vis_d[fill_q] = 1'b1;
                  fill_d           = fill_q + 4'd1;
                  if (fill_q == 4'd11) scan_end = 1'b1;
               end
            end
            if (addr_q == LAST_ADDR) scan_end = 1'b1;
            if (scan_end) begin
               state_d = PUBLISH;
            end else begin
               addr_d  = addr_q + 8'd1;
               state_d = ISSUE;
            end
         end
         PUBLISH: begin
            pub_x_d   = sh_x_q;
            pub_y_d   = sh_y_q;
            pub_z_d   = sh_z_q;
            pub_c_d   = sh_c_q;
            pub_dir_d = sh_dir_q;
            pub_id_d  = sh_id_q;
            pub_vis_d = sh_vis_q;
            upd_d     = 1'b1;
            state_d   = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         state_q   <= IDLE;
         t0_q      <= '0;
         addr_q    <= '0;
         fill_q    <= '0;
         wcnt_q    <= '0;
         upd_q     <= 1'b0;
         sh_x_q    <= '0;
         sh_y_q    <= '0;
         sh_z_q    <= '0;
         sh_c_q    <= '0;
         sh_dir_q  <= '0;
         sh_id_q   <= '0;
         sh_vis_q  <= '0;
         pub_x_q   <= '0;
         pub_y_q   <= '0;
         pub_z_q   <= '0;
         pub_c_q   <= '0;
         pub_dir_q <= '0;
         pub_id_q  <= '0;
         pub_vis_q <= '0;
      end else begin
         state_q   <= state_d;
         t0_q      <= t0_d;
         addr_q    <= addr_d;
         fill_q    <= fill_d;
         wcnt_q    <= wcnt_d;
         upd_q     <= upd_d;
         sh_x_q    <= sh_x_d;
         sh_y_q    <= sh_y_d;
         sh_z_q    <= sh_z_d;
         sh_c_q    <= sh_c_d;
         sh_dir_q  <= sh_dir_d;
         sh_id_q   <= sh_id_d;
         sh_vis_q  <= sh_vis_d;
         pub_x_q   <= pub_x_d;
         pub_y_q   <= pub_y_d;
         pub_z_q   <= pub_z_d;
         pub_c_q   <= pub_c_d;
         pub_dir_q <= pub_dir_d;
         pub_id_q  <= pub_id_d;
         pub_vis_q <= pub_vis_d;
      end
   end

   assign mem_addr_out        = addr_q;
   assign busy_out            = (state_q != IDLE);
   assign update_out          = upd_q;
   assign block_x_out         = pub_x_q;
   assign block_y_out         = pub_y_q;
   assign block_z_out         = pub_z_q;
   assign block_color_out     = pub_c_q;
   assign block_direction_out = pub_dir_q;
   assign block_ID_out        = pub_id_q;
   assign block_visible_out   = pub_vis_q;

endmodule
